// File: rtl/branch_pred_pkg.sv
// Shared types and defaults for the branch-prediction controller and its
// table-invalidation sweep.
package branch_pred_pkg;

    localparam int ENTRIES_DEF = 1024;
    localparam int IDX_W_DEF   = 10;

    // Branch-type encoding that marks "not a branch" in execute.
    localparam logic [1:0] NON_BRANCH = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DRAIN = 2'b10
    } sweep_state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_reg_t;

endpackage

// File: rtl/bp_sweep_fsm.sv
// Invalidation sweep: walks every buffer entry once, then holds busy for one
// drain cycle so the last write settles before fetch resumes.
module bp_sweep_fsm
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_i,
    output logic             we_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    sweep_state_t     r_state;
    logic             r_we;
    logic             r_busy;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_state <= SWEEP;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= DRAIN;
                        r_we    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign we_o   = r_we;
    assign idx_o  = r_idx;
    assign busy_o = r_busy;
    // High on the final write; the top clears the global history on this edge.
    assign done_o = (r_state == SWEEP) && (r_idx == LAST_IDX);

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch-prediction controller: carries fetch predictions to execute, resolves
// them, tracks global history and statistics, and drives the invalidate sweep.
module branch_pred_ctrl
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_d_i,
    input  logic             flush_d_i,
    input  logic             stall_e_i,
    input  logic             flush_e_i,
    input  logic             pc_src_pred_f_i,
    input  logic [31:0]      pred_pc_target_f_i,
    input  logic [1:0]       branch_op_e_i,
    input  logic             pc_src_res_e_i,
    input  logic [31:0]      pc_target_e_i,
    input  logic [31:0]      pc_plus4_e_i,
    input  logic             inv_req_i,
    output logic [1:0]       local_src_o,
    output logic             target_match_o,
    output logic             mispredict_e_o,
    output logic [31:0]      redirect_pc_e_o,
    output logic             inv_we_o,
    output logic [IDX_W-1:0] inv_idx_o,
    output logic             inv_busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pred_reg_t        r_pred_d;
    pred_reg_t        r_pred_e;
    logic [1:0]       r_ghr;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_br;
    logic             w_target_match;
    logic             w_mispredict;
    logic             w_resolve;
    logic             w_inv_we;
    logic [IDX_W-1:0] w_inv_idx;
    logic             w_inv_busy;
    logic             w_sweep_done;

    bp_sweep_fsm #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_sweep (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (inv_req_i),
        .we_o    (w_inv_we),
        .idx_o   (w_inv_idx),
        .busy_o  (w_inv_busy),
        .done_o  (w_sweep_done)
    );

    // F->D and D->E prediction registers; flush takes priority over stall.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pred_d <= '0;
            r_pred_e <= '0;
        end else begin
            if (flush_d_i) begin
                r_pred_d <= '0;
            end else if (!stall_d_i) begin
                r_pred_d <= '{taken: pc_src_pred_f_i, target: pred_pc_target_f_i};
            end

            if (flush_e_i) begin
                r_pred_e <= '0;
            end else if (!stall_e_i) begin
                r_pred_e <= r_pred_d;
            end
        end
    end

    // Execute-stage resolution against the carried prediction.
    assign w_br           = (branch_op_e_i != NON_BRANCH);
    assign w_target_match = (r_pred_e.target == pc_target_e_i);
    assign w_mispredict   = w_br & ((r_pred_e.taken != pc_src_res_e_i) |
                                    (pc_src_res_e_i & ~w_target_match));
    assign w_resolve      = w_br & ~stall_e_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ghr <= 2'b00;
        end else if (w_sweep_done) begin
            r_ghr <= 2'b00;
        end else if (w_resolve && !w_inv_busy) begin
            r_ghr <= {r_ghr[0], pc_src_res_e_i};
        end
    end

    // Statistics keep counting through a sweep and stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            r_branch_cnt <= sat_inc(r_branch_cnt);
            if (w_mispredict) begin
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end
        end
    end

    assign local_src_o     = r_ghr;
    assign target_match_o  = w_target_match;
    assign mispredict_e_o  = w_mispredict;
    assign redirect_pc_e_o = pc_src_res_e_i ? pc_target_e_i : pc_plus4_e_i;
    assign inv_we_o        = w_inv_we;
    assign inv_idx_o       = w_inv_idx;
    assign inv_busy_o      = w_inv_busy;
    assign branch_cnt_o    = r_branch_cnt;
    assign mispred_cnt_o   = r_mispred_cnt;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: randomized and directed stimulus
// against a cycle-level behavioural model of the controller.
module tb_branch_pred_ctrl;
    import branch_pred_pkg::*;

    localparam int ENT  = 1024;
    localparam int IW   = 10;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          stall_d_i, flush_d_i, stall_e_i, flush_e_i;
    logic          pc_src_pred_f_i;
    logic [31:0]   pred_pc_target_f_i;
    logic [1:0]    branch_op_e_i;
    logic          pc_src_res_e_i;
    logic [31:0]   pc_target_e_i, pc_plus4_e_i;
    logic          inv_req_i;
    logic [1:0]    local_src_o;
    logic          target_match_o, mispredict_e_o;
    logic [31:0]   redirect_pc_e_o;
    logic          inv_we_o;
    logic [IW-1:0] inv_idx_o;
    logic          inv_busy_o;
    logic [CW-1:0] branch_cnt_o, mispred_cnt_o;

    always #5 clk = ~clk;

    branch_pred_ctrl #(.ENTRIES(ENT), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .stall_d_i          (stall_d_i),
        .flush_d_i          (flush_d_i),
        .stall_e_i          (stall_e_i),
        .flush_e_i          (flush_e_i),
        .pc_src_pred_f_i    (pc_src_pred_f_i),
        .pred_pc_target_f_i (pred_pc_target_f_i),
        .branch_op_e_i      (branch_op_e_i),
        .pc_src_res_e_i     (pc_src_res_e_i),
        .pc_target_e_i      (pc_target_e_i),
        .pc_plus4_e_i       (pc_plus4_e_i),
        .inv_req_i          (inv_req_i),
        .local_src_o        (local_src_o),
        .target_match_o     (target_match_o),
        .mispredict_e_o     (mispredict_e_o),
        .redirect_pc_e_o    (redirect_pc_e_o),
        .inv_we_o           (inv_we_o),
        .inv_idx_o          (inv_idx_o),
        .inv_busy_o         (inv_busy_o),
        .branch_cnt_o       (branch_cnt_o),
        .mispred_cnt_o      (mispred_cnt_o)
    );

    typedef struct {
        bit          rst, sd, fd, se, fe, pt, res, req;
        logic [31:0] ptgt, tgt, p4;
        logic [1:0]  op;
    } in_t;

    typedef struct {
        logic [1:0]  ghr;
        bit          tm, mis, we, busy, chk_idx;
        logic [31:0] rpc;
        int          idx, bc, mc;
    } exp_t;

    // Model state: values visible after the most recent clock edge.
    logic [1:0]  m_ghr;
    bit          md_t, me_t;
    logic [31:0] md_g, me_g;
    int          m_bc, m_mc;
    int          m_sw = -1;   // cycles since sweep start; -1 when idle, ENT = drain

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic in_t zero_in();
        in_t v;
        v.rst = 0; v.sd = 0; v.fd = 0; v.se = 0; v.fe = 0; v.pt = 0;
        v.res = 0; v.req = 0; v.ptgt = '0; v.tgt = '0; v.p4 = '0; v.op = NON_BRANCH;
        return v;
    endfunction

    function automatic logic [31:0] pick_tgt();
        return 32'(($urandom % 4) + 1) << 8;
    endfunction

    function automatic in_t rnd_in(bit allow_req);
        in_t v = zero_in();
        v.sd   = ($urandom % 8) == 0;
        v.fd   = ($urandom % 10) == 0;
        v.se   = ($urandom % 8) == 0;
        v.fe   = ($urandom % 10) == 0;
        v.pt   = $urandom % 2;
        v.ptgt = pick_tgt();
        v.op   = 2'($urandom % 4);
        v.res  = $urandom % 2;
        v.tgt  = pick_tgt();
        v.p4   = $urandom & 32'h0000_FFFC;
        v.req  = allow_req && (($urandom % 40) == 0);
        return v;
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    function automatic exp_t expect_out(in_t v);
        exp_t e;
        bit br = (v.op != NON_BRANCH);
        e.tm      = (me_g == v.tgt);
        e.mis     = br && ((me_t != v.res) || (v.res && !e.tm));
        e.rpc     = v.res ? v.tgt : v.p4;
        e.ghr     = m_ghr;
        e.busy    = (m_sw >= 0);
        e.we      = (m_sw >= 0) && (m_sw < ENT);
        e.chk_idx = (m_sw != ENT);
        e.idx     = (m_sw < 0) ? 0 : m_sw;
        e.bc      = m_bc;
        e.mc      = m_mc;
        return e;
    endfunction

    task automatic model_edge(in_t v);
        bit br, tm, mis, ne_t;
        logic [31:0] ne_g;
        if (v.rst) begin
            m_ghr = 2'b00; md_t = 0; me_t = 0; md_g = '0; me_g = '0;
            m_bc = 0; m_mc = 0; m_sw = -1;
            return;
        end
        br  = (v.op != NON_BRANCH);
        tm  = (me_g == v.tgt);
        mis = br && ((me_t != v.res) || (v.res && !tm));
        if (br && !v.se) begin
            m_bc = sat(m_bc);
            if (mis) m_mc = sat(m_mc);
        end
        if (m_sw == ENT - 1) m_ghr = 2'b00;
        else if (br && !v.se && m_sw < 0) m_ghr = {m_ghr[0], v.res};
        ne_t = me_t; ne_g = me_g;
        if (v.fe) begin ne_t = 0; ne_g = '0; end
        else if (!v.se) begin ne_t = md_t; ne_g = md_g; end
        if (v.fd) begin md_t = 0; md_g = '0; end
        else if (!v.sd) begin md_t = v.pt; md_g = v.ptgt; end
        me_t = ne_t; me_g = ne_g;
        if (m_sw < 0) begin
            if (v.req) m_sw = 0;
        end else if (m_sw == ENT) m_sw = -1;
        else m_sw++;
    endtask

    task automatic apply(in_t v);
        reset_i            = v.rst;
        stall_d_i          = v.sd;
        flush_d_i          = v.fd;
        stall_e_i          = v.se;
        flush_e_i          = v.fe;
        pc_src_pred_f_i    = v.pt;
        pred_pc_target_f_i = v.ptgt;
        branch_op_e_i      = v.op;
        pc_src_res_e_i     = v.res;
        pc_target_e_i      = v.tgt;
        pc_plus4_e_i       = v.p4;
        inv_req_i          = v.req;
    endtask

    task automatic drive(in_t v);
        apply(v);
        q.push_back(expect_out(v));
        @(posedge clk);
        #1;
        model_edge(v);
    endtask

    // Prediction enters F, then resolves two cycles later in E.
    task automatic branch_seq(bit pt, logic [31:0] ptgt, bit res,
                              logic [31:0] tgt, logic [31:0] p4);
        in_t v = zero_in();
        v.pt = pt; v.ptgt = ptgt;
        drive(v);
        drive(zero_in());
        v = zero_in();
        v.op = 2'b01; v.res = res; v.tgt = tgt; v.p4 = p4;
        drive(v);
        drive(zero_in());
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            check("local_src",    32'(local_src_o),     32'(me.ghr));
            check("target_match", 32'(target_match_o),  32'(me.tm));
            check("mispredict",   32'(mispredict_e_o),  32'(me.mis));
            check("redirect_pc",  redirect_pc_e_o,      me.rpc);
            check("inv_we",       32'(inv_we_o),        32'(me.we));
            check("inv_busy",     32'(inv_busy_o),      32'(me.busy));
            if (me.chk_idx) check("inv_idx", 32'(inv_idx_o), me.idx[31:0]);
            check("branch_cnt",   32'(branch_cnt_o),    me.bc[31:0]);
            check("mispred_cnt",  32'(mispred_cnt_o),   me.mc[31:0]);
        end
    end

    initial begin
        in_t v;
        v = zero_in();
        v.rst = 1;
        apply(v);
        @(posedge clk);
        #1;
        model_edge(v);
        drive(v);
        drive(v);

        // Directed resolution cases.
        branch_seq(1, 32'h100, 1, 32'h100, 32'h4);
        branch_seq(0, 32'h0,   1, 32'h200, 32'h8);
        branch_seq(1, 32'h300, 1, 32'h304, 32'hC);
        branch_seq(1, 32'h500, 0, 32'h600, 32'h44);

        // Hold execute for three cycles while branches are presented.
        v = zero_in();
        v.pt = 1; v.ptgt = 32'h700;
        drive(v);
        drive(zero_in());
        for (int i = 0; i < 3; i++) begin
            v = zero_in();
            v.se = 1; v.op = 2'b10; v.res = i[0]; v.tgt = 32'h700;
            drive(v);
        end
        v = zero_in();
        v.op = 2'b10; v.res = 1; v.tgt = 32'h700;
        drive(v);

        // Flush and stall together on the F->D register.
        v = zero_in();
        v.pt = 1; v.ptgt = 32'h900;
        drive(v);
        v.fd = 1; v.sd = 1;
        drive(v);
        drive(zero_in());
        v = zero_in();
        v.op = 2'b11; v.res = 1; v.tgt = 32'h0;
        drive(v);

        for (int i = 0; i < 400; i++) drive(rnd_in(0));

        // Full sweep with a second request mid-way and branches throughout.
        v = rnd_in(0);
        v.req = 1;
        drive(v);
        for (int i = 0; i < 1200 && m_sw >= 0; i++) begin
            v = rnd_in(1);
            if (m_sw == 300) v.req = 1;
            drive(v);
        end
        for (int i = 0; i < 4; i++) drive(rnd_in(0));

        // Sweep aborted by reset partway through.
        v = zero_in();
        v.req = 1;
        drive(v);
        for (int i = 0; i < 1200 && m_sw >= 0; i++) begin
            v = rnd_in(0);
            if (m_sw == 500) v.rst = 1;
            drive(v);
        end
        for (int i = 0; i < 4; i++) drive(rnd_in(0));

        for (int i = 0; i < 300; i++) drive(rnd_in(0));

        // Drive both counters into saturation with mispredicted branches.
        for (int i = 0; i < 2 * CMAX + 8; i++) begin
            v = zero_in();
            v.op = 2'b01; v.res = 1; v.tgt = 32'h1234;
            drive(v);
        end
        drive(zero_in());

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
Controls the branching buffer. It holds the 2-bit global history that selects each entry's local predictor (`local_src_o`). It carries fetch-stage predictions down to execute and resolves them there, producing `target_match_o`, the mispredict flag and the redirect PC. It also runs a table-invalidation sweep and keeps prediction statistics. It sits between the hazard unit, the fetch/execute datapath and the branching buffer.

Parameters:
ENTRIES, 1024, number of buffer entries swept on invalidate (power of two)
IDX_W, 10, log2(ENTRIES); width of the sweep index
CNT_W, 32, width of the statistic counters

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
stall_d_i  in  1  hold the F->D prediction register
flush_d_i  in  1  clear the F->D prediction register
stall_e_i  in  1  hold the D->E prediction register
flush_e_i  in  1  clear the D->E prediction register
pc_src_pred_f_i  in  1  predicted taken, from the buffer
pred_pc_target_f_i  in  32  predicted target, from the buffer
branch_op_e_i  in  2  branch type in execute; `NON_BRANCH = not a branch
pc_src_res_e_i  in  1  resolved taken in execute
pc_target_e_i  in  32  resolved target
pc_plus4_e_i  in  32  fall-through PC
inv_req_i  in  1  request a full-table invalidate (pulse)
local_src_o  out  2  global history, driven to the buffer
target_match_o  out  1  predicted target equals resolved target
mispredict_e_o  out  1  execute-stage misprediction
redirect_pc_e_o  out  32  correct PC after a misprediction
inv_we_o  out  1  invalidate write strobe
inv_idx_o  out  IDX_W  entry currently being invalidated
inv_busy_o  out  1  sweep active; the hazard unit stalls fetch
branch_cnt_o  out  CNT_W  branches resolved
mispred_cnt_o  out  CNT_W  mispredictions

Behaviour:
- Reset clears everything:
  - GHR = 2'b00.
  - Both prediction registers = 0 (taken = 0, target = 0).
  - FSM goes to IDLE; `inv_idx_o` = 0; `inv_we_o` and `inv_busy_o` = 0.
  - Both counters = 0.
  - `mispredict_e_o` = 0, since the E register is cleared.
- Reset during a sweep aborts the sweep the same cycle; IDLE is entered on the next edge.
- Prediction pipeline:
  - The F->D and D->E registers each hold {taken, target}.
  - Flush beats stall, and clears the register to 0.
  - Stall holds the register; otherwise it loads from the previous stage.
- Resolution (combinational in E):
  - br = (branch_op_e_i != `NON_BRANCH`).
  - `target_match_o` = (pred_target_e == pc_target_e_i), regardless of br.
  - `mispredict_e_o` = br & ((pred_taken_e != pc_src_res_e_i) | (pc_src_res_e_i & ~target_match_o)).
  - `redirect_pc_e_o` = pc_src_res_e_i ? pc_target_e_i : pc_plus4_e_i.
- GHR (`local_src_o` = GHR):
  - On a clock edge with br & ~stall_e_i & ~inv_busy_o: GHR <= {GHR[0], pc_src_res_e_i}.
  - The new value is visible the next cycle.
- Counters:
  - On br & ~stall_e_i: `branch_cnt_o`++, and `mispred_cnt_o`++ if mispredict.
  - Both saturate at all-ones; no wrap.
  - They count during a sweep as well.
- Sweep FSM:
  - IDLE -> SWEEP on inv_req_i. Then `inv_busy_o` = 1, `inv_we_o` = 1 and `inv_idx_o` starts at 0.
  - In SWEEP, `inv_idx_o` increments by 1 each cycle.
  - When `inv_idx_o` = ENTRIES-1, go to DRAIN and clear GHR to 0.
  - DRAIN lasts 1 cycle with `inv_busy_o` = 1 and `inv_we_o` = 0, then returns to IDLE with `inv_idx_o` = 0.
  - `inv_req_i` is ignored during SWEEP and DRAIN; there is no queuing.
  - Total busy time is ENTRIES+1 cycles; the first write lands on the cycle after the request.
- Simultaneous events:
  - A request and a branch resolving in the same cycle: the GHR update is applied (not yet busy); the sweep starts next cycle.
  - flush_e_i together with a mispredict: outputs reflect the current E contents; the register clears on the edge.

Decomposition:
- Package branch_pred_pkg:
  - `sweep_state_t` enum {IDLE, SWEEP, DRAIN}
  - ENTRIES and IDX_W defaults
  - `pred_reg_t` struct {taken, target[31:0]}
  - Reuses `NON_BRANCH` from control_macros.
- Sub-module bp_sweep_fsm holds the FSM and index counter. Ports: `clk_i`, `reset_i`, req, `we`, `idx`, `busy`, done pulse.
- Resolution, GHR, pipeline registers and counters stay in the top level.

Test Plan:
- Taken branch with target match: pred F = {1, 0x100}; two cycles later E has br, res = 1, target = 0x100 -> `mispredict_e_o` = 0, `target_match_o` = 1, `branch_cnt_o` = 1, GHR 00 -> 01.
- Direction mispredict: pred = {0, 0}; E has res = 1, target = 0x200 -> `mispredict_e_o` = 1, `redirect_pc_e_o` = 0x200, `mispred_cnt_o` = 1.
- Target mispredict and not-taken redirect:
  - pred = {1, 0x300}, res = 1, target = 0x304 -> mispredict = 1, `target_match_o` = 0.
  - pred = {1, x}, res = 0, pc_plus4 = 0x44 -> redirect = 0x44.
- Stall/flush:
  - stall_e_i for 3 cycles holds pred_e; GHR and counters do not change.
  - flush_d_i together with stall_d_i -> F->D register = 0.
- Sweep: pulse inv_req_i with ENTRIES = 1024:
  - `inv_we_o` is high for exactly 1024 cycles with idx 0..1023, then a 1-cycle DRAIN, then busy falls.
  - GHR = 0 after the sweep.
  - A second request mid-sweep is ignored.
  - `reset_i` at idx = 500 -> busy = 0 and idx = 0 next cycle.
- Saturation: preload both counters to all-ones, then resolve a mispredicted branch -> both stay all-ones.
